// File: rtl/memory_palette_serializer.sv
// Palette-lookup pixel serializer: unpacks pixel-code words MSB-first and streams one
// palette colour per beat over valid/ready, flagging the last pixel of each word.
module memory_palette_serializer #(
   parameter int unsigned CODE_W       = 4,
   parameter int unsigned PIX_PER_WORD = 4,
   parameter int unsigned COLOR_W      = 24
) (
   input  logic                             CLK,
   input  logic                             RST_N,
   input  logic [CODE_W*PIX_PER_WORD-1:0]   MEM_OUT,
   input  logic                             MEM_VALID,
   output logic                             MEM_READY,
   input  logic                             PAL_WE,
   input  logic [CODE_W-1:0]                PAL_ADDR,
   input  logic [COLOR_W-1:0]               PAL_DATA,
   output logic [COLOR_W-1:0]               PIX_RGB,
   output logic                             PIX_VALID,
   input  logic                             PIX_READY,
   output logic                             PIX_LAST
);

   localparam int unsigned WordW = CODE_W * PIX_PER_WORD;
   localparam int unsigned Depth = 2 ** CODE_W;
   localparam int unsigned RemW  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

   logic [COLOR_W-1:0] pal_q [Depth];
   logic [COLOR_W-1:0] rgb_q, rgb_d;
   logic               valid_q, valid_d;
   logic [WordW-1:0]   shift_q, shift_d;
   logic [RemW-1:0]    rem_q, rem_d;

   logic               accept;
   logic               advance;
   logic [CODE_W-1:0]  mem_code;
   logic [CODE_W-1:0]  next_code;

   assign mem_code  = MEM_OUT[WordW-1 -: CODE_W];
   assign next_code = shift_q[WordW-1 -: CODE_W];

   assign MEM_READY = !valid_q || (PIX_READY && (rem_q == '0));
   assign accept    = MEM_VALID && MEM_READY;
   assign advance   = valid_q && PIX_READY && (rem_q != '0);

   assign PIX_RGB   = rgb_q;
   assign PIX_VALID = valid_q;
   assign PIX_LAST  = valid_q && (rem_q == '0);

   // advance and accept are mutually exclusive: MEM_READY with valid_q needs rem_q == 0.
   always_comb begin
      rgb_d   = rgb_q;
      valid_d = valid_q;
      shift_d = shift_q;
      rem_d   = rem_q;
      if (advance) begin
         rgb_d   = pal_q[next_code];
         shift_d = shift_q << CODE_W;
         rem_d   = rem_q - RemW'(1);
      end else if (accept) begin
         rgb_d   = pal_q[mem_code];
         valid_d = 1'b1;
         shift_d = MEM_OUT << CODE_W;
         rem_d   = RemW'(PIX_PER_WORD - 1);
      end else if (valid_q && PIX_READY) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rgb_q   <= '0;
         valid_q <= 1'b0;
         shift_q <= '0;
         rem_q   <= '0;
      end else begin
         rgb_q   <= rgb_d;
         valid_q <= valid_d;
         shift_q <= shift_d;
         rem_q   <= rem_d;
      end
   end

   // Lookups above sample pal_q before this edge's write lands (read-before-write).
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < Depth; i++) begin
            pal_q[i] <= '0;
         end
      end else if (PAL_WE) begin
         pal_q[PAL_ADDR] <= PAL_DATA;
      end
   end

endmodule

// File: doc/memory_palette_serializer.md
Name: memory_palette_serializer

Overview:
Parametrised successor to the combinational pixel-code decoder. Accepts packed pixel-code words from video memory over a valid/ready handshake and looks each code up in a run-time-writable palette register file. Emits one COLOR_W-bit colour per beat on a stallable valid/ready stream, with an end-of-word marker. Sits between the frame memory read port and the VGA pixel pipeline.

Parameters:
CODE_W, 4, bits per pixel code; palette depth = 2**CODE_W
PIX_PER_WORD, 4, pixel codes packed per memory word (>=1); WORD_W = CODE_W*PIX_PER_WORD (derived, default 16)
COLOR_W, 24, bits per palette colour (RGB888 by default)

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
MEM_OUT  in  WORD_W  packed pixel-code word
MEM_VALID  in  1  MEM_OUT valid
MEM_READY  out  1  block accepts MEM_OUT this cycle
PAL_WE  in  1  palette write enable
PAL_ADDR  in  CODE_W  palette entry to write
PAL_DATA  in  COLOR_W  colour to write
PIX_RGB  out  COLOR_W  current pixel colour
PIX_VALID  out  1  PIX_RGB valid
PIX_READY  in  1  downstream accepts pixel
PIX_LAST  out  1  PIX_RGB is final pixel of its word

Behaviour:
- Reset (async, RST_N=0): PIX_RGB=0, PIX_VALID=0, PIX_LAST=0, remaining-count REM=0, shift register=0, all palette entries=0. MEM_READY=1 after reset (combinational).
- Pixel order: MSB-first; pixel 0 = MEM_OUT[WORD_W-1 -: CODE_W].
- State: output register (PIX_RGB, PIX_VALID), shift register holding the unsent codes, REM in 0..PIX_PER_WORD-1. REM width = max(1, clog2(PIX_PER_WORD)).
- MEM_READY = !PIX_VALID || (PIX_READY && REM==0). Combinational; does not depend on MEM_VALID.
- Word accept (MEM_VALID && MEM_READY) at edge t: PIX_RGB <= palette[code0], PIX_VALID <= 1, shift reg <= codes 1..N-1, REM <= PIX_PER_WORD-1. Latency is one cycle: pixel visible after edge t.
- Pixel consumed (PIX_VALID && PIX_READY):
  - REM>0: load palette[next code], shift, REM--.
  - REM==0 and MEM_VALID: accept new word, no bubble.
  - Otherwise: PIX_VALID <= 0.
- Stall (PIX_VALID && !PIX_READY): PIX_RGB, PIX_LAST, REM and shift register hold; MEM_READY=0.
- PIX_LAST = PIX_VALID && REM==0 (combinational from state). With PIX_PER_WORD=1, every pixel is LAST and the block sustains one word per cycle.
- Palette write: when PAL_WE=1, the entry is updated at the edge, independent of the stream. A lookup at the same edge reads the pre-write value (read-before-write). Subsequent lookups see the new value. Writes are never blocked.
- Colour is a pure palette copy: no arithmetic, no width conversion.
- Reset mid-word: pending codes are discarded, palette cleared, stream restarts idle.

Test Plan:
1. Assert RST_N=0 then release -> PIX_VALID=0, PIX_RGB=0, PIX_LAST=0, MEM_READY=1. Send word 16'h0000 -> pixel 24'h000000 x4 (palette cleared).
2. Write palette[A]=eeff41 and palette[5]=039be5; send 16'hA55A with PIX_READY=1 -> eeff41, 039be5, 039be5, eeff41 on 4 consecutive cycles. PIX_LAST on 4th only; MEM_READY=1 only during 4th.
3. As in scenario 2, but drop PIX_READY for 3 cycles while pixel 1 is shown -> 039be5 held, PIX_LAST=0, MEM_READY=0. Stream resumes with no lost or duplicated pixels.
4. Two words back-to-back, 16'hA55A then 16'h5AA5, with MEM_VALID held -> 8 pixels with no idle cycle. PIX_LAST on pixels 4 and 8.
5. PAL_WE writes palette[A]=ffffff in the same cycle that word 16'hAAAA is accepted -> first pixel eeff41, remaining three ffffff.
6. Pull RST_N low after 2 pixels of 16'hA55A -> immediately PIX_VALID=0, REM=0. After release, a resent 16'hA55A yields 000000 x4.
